ps2_keycode: RTL and testbench

Receives scancodes from a PS/2 keyboard, decodes Set-2 make/break/extended sequences and presents the currently held key as an 8-bit USB-HID-style keycode. It is the producer of the `keycode` bus consumed by the player-motion logic (A=0x04, D=0x07, Space=0x2C). Its output is identical in meaning to the keycode from the USB path, so the two sources are interchangeable.

---
 rtl/ps2_keycode.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_keycode.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode.sv
// PS/2 Set-2 keyboard receiver: conditions the raw pins, deframes bytes and
// turns make/break/extended sequences into a held-key HID keycode.
module ps2_keycode #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_event,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          sample;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_err_q, frame_err_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          key_event_q, key_event_d;
  logic [7:0]    hid;

  // Input conditioning: the filtered clock only flips after FILTER
  // consecutive synchronized samples that disagree with it.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign sample = filt_clk_q & ~filt_clk_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (state_q == S_IDLE || sample) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_LAST) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end

    if (sample) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if ((^{shift_q, parity_q}) && dat_s2_q) byte_valid_d = 1'b1;
          else                                     frame_err_d  = 1'b1;
        end
      endcase
    end else if (state_q != S_IDLE && to_cnt_q == TO_LAST) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // The shift register holds the received byte while byte_valid_q is high.
  always_comb begin
    hid = 8'h00;
    if (ext_q) begin
      case (shift_q)
        8'h6B:   hid = 8'h50;
        8'h74:   hid = 8'h4F;
        default: hid = 8'h00;
      endcase
    end else begin
      case (shift_q)
        8'h1C:   hid = 8'h04;
        8'h23:   hid = 8'h07;
        8'h1D:   hid = 8'h1A;
        8'h1B:   hid = 8'h16;
        8'h29:   hid = 8'h2C;
        8'h5A:   hid = 8'h28;
        8'h76:   hid = 8'h29;
        default: hid = 8'h00;
      endcase
    end
  end

  always_comb begin
    keycode_d   = keycode_q;
    key_event_d = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    if (frame_err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Releasing an older key must not clear a newer one.
        if (hid != 8'h00) begin
          if (!brk_q && hid != keycode_q) begin
            keycode_d   = hid;
            key_event_d = 1'b1;
          end else if (brk_q && hid == keycode_q) begin
            keycode_d   = 8'h00;
            key_event_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      keycode_q    <= 8'h00;
      key_event_q  <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      keycode_q    <= keycode_d;
      key_event_q  <= key_event_d;
    end
  end

  assign keycode   = keycode_q;
  assign key_event = key_event_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Bench for ps2_keycode: bit-level PS/2 frames, a reference decoder feeding
// an expected-event scoreboard, and per-scenario keycode checks.
module tb_ps2_keycode;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 20;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_events = 0;
  int n_errs = 0;

  typedef struct {
    logic [7:0] code;
    int         cyc;
  } ev_t;

  ev_t ev_q[$];
  int  err_q[$];

  // Reference model state and map table: {ext, scancode, hid}
  logic       m_ext = 1'b0;
  logic       m_brk = 1'b0;
  logic [7:0] m_key = 8'h00;
  logic [16:0] map_tbl [9] = '{17'h0_1C_04, 17'h0_23_07, 17'h0_1D_1A,
                               17'h0_1B_16, 17'h0_29_2C, 17'h0_5A_28,
                               17'h0_76_29, 17'h1_6B_50, 17'h1_74_4F};

  ps2_keycode #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .keycode  (keycode),
    .key_event(key_event),
    .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] lookup(input logic e, input logic [7:0] sc);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 9; i++)
      if (map_tbl[i][16] == e && map_tbl[i][15:8] == sc) r = map_tbl[i][7:0];
    return r;
  endfunction

  // c = cycle of the posedge just before the stop-bit clock fall
  task automatic model_byte(input logic [7:0] b, input int c);
    logic [7:0] h;
    ev_t e;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      h = lookup(m_ext, b);
      if (h != 8'h00) begin
        if (!m_brk && h != m_key) begin
          m_key = h; e.code = h; e.cyc = c + FILTER + 3; ev_q.push_back(e);
        end else if (m_brk && h == m_key) begin
          m_key = 8'h00; e.code = 8'h00; e.cyc = c + FILTER + 3; ev_q.push_back(e);
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int n_bits,
                            input int glitch_bit);
    logic [10:0] bits;
    int c;
    bits = {1'b1, (bad_par ? (^b) : ~(^b)), b, 1'b0};
    c = 0;
    for (int i = 0; i < n_bits; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        repeat (HALF / 2) @(posedge Clk);
        #1 ps2_clk = 1'b0;
        repeat (FILTER - 3) @(posedge Clk);
        #1 ps2_clk = 1'b1;
      end
      repeat (HALF) @(posedge Clk);
      #1 ps2_clk = 1'b0;
      c = cyc;
      if (i == 10) begin
        if (bad_par) begin
          err_q.push_back(c + FILTER + 2);
          m_ext = 1'b0;
          m_brk = 1'b0;
        end else begin
          model_byte(b, c);
        end
      end
      repeat (HALF) @(posedge Clk);
      #1 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (n_bits < 11) begin
      err_q.push_back(c + FILTER + TIMEOUT + 2);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    repeat (HALF) @(posedge Clk);
    #1;
  endtask

  initial begin : monitor
    ev_t e;
    int ec;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        if (key_event === 1'b1 && frame_err === 1'b1) begin
          checks++; errors++;
          $display("FAIL overlap: key_event and frame_err both high at cycle %0d", cyc);
        end
        if (key_event === 1'b1) begin
          n_events++; checks++;
          if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_key_event: keycode=%h at cycle %0d, none expected", keycode, cyc);
          end else begin
            e = ev_q.pop_front();
            if (keycode !== e.code || cyc != e.cyc) begin
              errors++;
              $display("FAIL key_event: keycode=%h cycle=%0d, expected keycode=%h cycle=%0d",
                       keycode, cyc, e.code, e.cyc);
            end
          end
        end
        if (frame_err === 1'b1) begin
          n_errs++; checks++;
          if (err_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame_err: at cycle %0d, none expected", cyc);
          end else begin
            ec = err_q.pop_front();
            if (cyc != ec) begin
              errors++;
              $display("FAIL frame_err_timing: cycle=%0d, expected cycle=%0d", cyc, ec);
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    checks++;
    if (keycode !== 8'h00 || key_event !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: keycode=%h key_event=%b frame_err=%b, expected 00 0 0",
               keycode, key_event, frame_err);
    end
    Reset = 1'b0;
    repeat (1000) @(posedge Clk);
    #1;
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL idle_keycode: keycode=%h, expected 00", keycode);
    end
    checks++;
    if (n_events != 0 || n_errs != 0) begin
      errors++; $display("FAIL idle_pulses: events=%0d errs=%0d, expected 0 0", n_events, n_errs);
    end
  endtask

  task automatic test_make_break;
    int ev0, er0;
    ev0 = n_events; er0 = n_errs;
    send_frame(8'h1C, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h04) begin
      errors++; $display("FAIL make_A: keycode=%h, expected 04", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL break_A: keycode=%h, expected 00", keycode);
    end
    checks++;
    if (n_events - ev0 != 2 || n_errs != er0) begin
      errors++;
      $display("FAIL make_break_counts: events=%0d errs=%0d, expected 2 0", n_events - ev0, n_errs - er0);
    end
  endtask

  task automatic test_two_keys;
    int ev0;
    ev0 = n_events;
    send_frame(8'h1C, 1'b0, 11, -1);
    send_frame(8'h23, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h07) begin
      errors++; $display("FAIL press_D_over_A: keycode=%h, expected 07", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h07) begin
      errors++; $display("FAIL release_old_A: keycode=%h, expected 07", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h23, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL release_D: keycode=%h, expected 00", keycode);
    end
    checks++;
    if (n_events - ev0 != 3) begin
      errors++; $display("FAIL two_keys_events: events=%0d, expected 3", n_events - ev0);
    end
  endtask

  task automatic test_parity_error;
    int er0;
    er0 = n_errs;
    send_frame(8'h29, 1'b1, 11, -1);
    checks++;
    if (keycode !== 8'h00 || n_errs - er0 != 1) begin
      errors++;
      $display("FAIL bad_parity: keycode=%h errs=%0d, expected 00 1", keycode, n_errs - er0);
    end
    send_frame(8'h29, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h2C) begin
      errors++; $display("FAIL space_after_error: keycode=%h, expected 2c", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h29, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL release_space: keycode=%h, expected 00", keycode);
    end
  endtask

  task automatic test_extended;
    int ev0;
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'h6B, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h50) begin
      errors++; $display("FAIL ext_left: keycode=%h, expected 50", keycode);
    end
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h6B, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL ext_left_release: keycode=%h, expected 00", keycode);
    end
    ev0 = n_events;
    send_frame(8'h6B, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00 || n_events != ev0) begin
      errors++;
      $display("FAIL bare_6b: keycode=%h events=%0d, expected 00 0", keycode, n_events - ev0);
    end
    ev0 = n_events;
    for (int i = 0; i < 5; i++) send_frame(8'h1C, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h04 || n_events - ev0 != 1) begin
      errors++;
      $display("FAIL typematic: keycode=%h events=%0d, expected 04 1", keycode, n_events - ev0);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h1C, 1'b0, 11, -1);
  endtask

  task automatic test_mapping;
    send_frame(8'h5A, 1'b0, 11, -1);
    send_frame(8'h76, 1'b0, 11, -1);
    send_frame(8'h1B, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h16) begin
      errors++; $display("FAIL map_S: keycode=%h, expected 16", keycode);
    end
    send_frame(8'hAA, 1'b0, 11, -1);
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'h74, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h4F) begin
      errors++; $display("FAIL ext_right: keycode=%h, expected 4f", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h74, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h4F) begin
      errors++; $display("FAIL bare_74_release: keycode=%h, expected 4f", keycode);
    end
  endtask

  task automatic test_timeout;
    int er0;
    er0 = n_errs;
    send_frame(8'h55, 1'b0, 5, -1);
    repeat (TIMEOUT + 100) @(posedge Clk);
    #1;
    checks++;
    if (n_errs - er0 != 1) begin
      errors++; $display("FAIL timeout_err: errs=%0d, expected 1", n_errs - er0);
    end
    send_frame(8'h23, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h07) begin
      errors++; $display("FAIL after_timeout: keycode=%h, expected 07", keycode);
    end
  endtask

  task automatic test_glitch;
    send_frame(8'h1D, 1'b0, 11, 3);
    checks++;
    if (keycode !== 8'h1A) begin
      errors++; $display("FAIL glitch_W: keycode=%h, expected 1a", keycode);
    end
    send_frame(8'hF0, 1'b0, 11, -1);
    send_frame(8'h1D, 1'b0, 11, -1);
    checks++;
    if (keycode !== 8'h00) begin
      errors++; $display("FAIL release_W: keycode=%h, expected 00", keycode);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_two_keys();
    test_parity_error();
    test_extended();
    test_mapping();
    test_timeout();
    test_glitch();
    repeat (100) @(posedge Clk);
    #1;
    checks++;
    if (ev_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending events=%0d errs=%0d, expected 0 0",
               ev_q.size(), err_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
